// File: rtl/sr_pkg.sv
// Shared encodings for the SR bank driver: FSM states and the {s,r} command
// values understood by the SR flop cells.
package sr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // {s,r} as decoded by the flop cell; ILLEGAL is listed only to name it.
   localparam logic [1:0] HOLD    = 2'b00;
   localparam logic [1:0] RST     = 2'b01;
   localparam logic [1:0] SET     = 2'b10;
   localparam logic [1:0] ILLEGAL = 2'b11;

   typedef struct packed {
      logic s;
      logic r;
   } sr_cmd_t;

endpackage

// File: rtl/sr_cmd_select.sv
// Per-channel command picker: drive the bank bit toward the target bit.
// Only HOLD, SET or RST can come out; ILLEGAL is unreachable by construction.
module sr_cmd_select
   import sr_pkg::*;
(
   input  logic       tgt,
   input  logic       shd,
   output logic [1:0] cmd
);

   always_comb begin
      cmd = HOLD;
      if (tgt && !shd)
         cmd = SET;
      else if (!tgt && shd)
         cmd = RST;
   end

endmodule

// File: rtl/sr_bank_driver.sv
// Walks a latched target pattern one channel per cycle, issuing registered
// S/R pulses to an SR flop bank and tracking its state in a shadow register.
// Optional readback compare in DONE is enabled with SRDRV_READBACK_EN.
module sr_bank_driver
   import sr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] shadow,
   input  logic [WIDTH-1:0] q_fb,
   output logic             mismatch
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   state_t                     state, nxt;
   logic [IW-1:0]              idx;
   logic [WIDTH-1:0]           tgt_q;
   logic [WIDTH-1:0][1:0]      cmd;
   sr_cmd_t                    cur;
   logic [WIDTH-1:0]           sel;

   for (genvar g = 0; g < WIDTH; g++) begin : g_sel
      sr_cmd_select u_sel (
         .tgt (tgt_q[g]),
         .shd (shadow[g]),
         .cmd (cmd[g])
      );
   end

   assign cur = sr_cmd_t'(cmd[idx]);
   assign sel = WIDTH'(1) << idx;

   assign tgt_ready = (state == IDLE);
   assign busy      = (state == SCAN) || (state == DONE);

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (tgt_valid) nxt = SCAN;
         SCAN:    if (idx == LAST) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         tgt_q  <= '0;
         s      <= '0;
         r      <= '0;
         shadow <= '0;
         done   <= 1'b0;
      end else begin
         state <= nxt;
         s     <= '0;
         r     <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (tgt_valid) begin
                  tgt_q <= tgt_data;
                  idx   <= '0;
               end
            end
            SCAN: begin
               // sel is one-hot, so at most one channel pulses per cycle
               s      <= cur.s ? sel : '0;
               r      <= cur.r ? sel : '0;
               shadow <= (shadow | (cur.s ? sel : '0)) & ~(cur.r ? sel : '0);
               if (idx != LAST)
                  idx <= idx + IW'(1);
            end
            DONE:    done <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef SRDRV_READBACK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mismatch <= 1'b0;
      else if (state == DONE && q_fb != shadow)
         mismatch <= 1'b1;
   end
`else
   logic unused_qfb;
   assign unused_qfb = ^q_fb;
   assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver (WIDTH=8) with hand-computed expectations.
module tb_sr_bank_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       tgt_valid;
   logic [7:0] tgt_data;
   logic       tgt_ready;
   logic [7:0] s, r, shadow, q_fb;
   logic       busy, done, mismatch;

   int n_cmp = 0;
   int n_err = 0;

   sr_bank_driver #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .tgt_valid (tgt_valid),
      .tgt_data  (tgt_data),
      .tgt_ready (tgt_ready),
      .s         (s),
      .r         (r),
      .busy      (busy),
      .done      (done),
      .shadow    (shadow),
      .q_fb      (q_fb),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation: handshake, 8 scan pulses, done pulse.
   task automatic run(input logic [7:0] data, input logic [7:0] es,
                      input logic [7:0] er, input logic [7:0] qfb);
      logic [7:0] m;
      check("ready_pre", tgt_ready, 1);
      tgt_valid = 1'b1;
      tgt_data  = data;
      q_fb      = qfb;
      tick;
      tgt_valid = 1'b0;
      tgt_data  = ~data;
      check("busy_start", busy, 1);
      for (int k = 0; k < 8; k++) begin
         tick;
         m = 8'h01 << k;
         check($sformatf("s_ch%0d", k), s, es & m);
         check($sformatf("r_ch%0d", k), r, er & m);
         check($sformatf("nodone_ch%0d", k), done, 0);
      end
      tick;
      check("done", done, 1);
      check("s_done", s, 0);
      check("r_done", r, 0);
      check("ready_done", tgt_ready, 1);
      check("shadow", shadow, data);
      tick;
      check("done_clr", done, 0);
   endtask

   initial begin
      logic [7:0] acc;
      reset     = 1'b1;
      tgt_valid = 1'b0;
      tgt_data  = 8'h00;
      q_fb      = 8'h00;
      tick;
      tick;
      check("rst_s", s, 0);
      check("rst_r", r, 0);
      check("rst_shadow", shadow, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mismatch", mismatch, 0);
      reset = 1'b0;
      tick;
      check("rst_ready", tgt_ready, 1);

      // 0 -> A5: sets only; A5 -> 5A: full swap; 5A -> 3C; 3C -> 3C: all hold
      run(8'hA5, 8'hA5, 8'h00, 8'hA5);
      run(8'h5A, 8'h5A, 8'hA5, 8'h5A);
      run(8'h3C, 8'h24, 8'h42, 8'h3C);
      run(8'h3C, 8'h00, 8'h00, 8'h3C);

      // async reset mid-scan (idx=3) with target FF from shadow 3C
      tgt_valid = 1'b1;
      tgt_data  = 8'hFF;
      tick;
      tgt_valid = 1'b0;
      tick;
      check("ab_s0", s, 8'h01);
      tick;
      check("ab_s1", s, 8'h02);
      tick;
      check("ab_busy", busy, 1);
      reset = 1'b1;
      #1;
      check("ab_s", s, 0);
      check("ab_r", r, 0);
      check("ab_shadow", shadow, 0);
      check("ab_busy_rst", busy, 0);
      #2;
      reset = 1'b0;
      tick;
      check("ab_ready", tgt_ready, 1);
      acc = 8'h00;
      for (int k = 0; k < 10; k++) begin
         tick;
         acc = acc | s | r;
      end
      check("ab_no_pulse", acc, 0);
      check("ab_shadow_hold", shadow, 0);

      // valid held through busy with changing data; second handshake at +10
      tgt_valid = 1'b1;
      tgt_data  = 8'h11;
      q_fb      = 8'h11;
      tick;
      tgt_data = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         tick;
         tgt_data = 8'(k * 37 + 5);
      end
      check("b2b_not_ready", tgt_ready, 0);
      tick;
      check("b2b_done1", done, 1);
      check("b2b_shadow1", shadow, 8'h11);
      tgt_data = 8'h33;
      q_fb     = 8'h33;
      tick;
      check("b2b_second_hs", busy, 1);
      tgt_valid = 1'b0;
      for (int k = 0; k < 8; k++) tick;
      check("b2b_done2_early", done, 0);
      tick;
      check("b2b_done2", done, 1);
      check("b2b_shadow2", shadow, 8'h33);
      tick;

      // readback: bank reports 0E instead of 0F in DONE
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick;
      run(8'h0F, 8'h0F, 8'h00, 8'h0E);
`ifdef SRDRV_READBACK_EN
      check("rb_mismatch_set", mismatch, 1);
`else
      check("rb_mismatch_off", mismatch, 0);
`endif
      run(8'h0F, 8'h00, 8'h00, 8'h0F);
`ifdef SRDRV_READBACK_EN
      check("rb_mismatch_sticky", mismatch, 1);
`else
      check("rb_mismatch_off2", mismatch, 0);
`endif
      reset = 1'b1;
      #2;
      reset = 1'b0;
      check("rb_mismatch_clr", mismatch, 0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
